// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locked sharing of one UART TX byte port with optional tag prefix
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         MAX_BURST    = 16,
  parameter int         TAG_EN       = 1,
  parameter logic [7:0] TAG_BASE     = 8'h80,
  parameter int         IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_data_valid,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, sel, j;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0] burst_q, burst_d;
  logic [CW-1:0] idle_q, idle_d;
  logic timeout_q, timeout_d, found, accept, leave;
  logic [7:0] req_byte [NUM_REQ];
  always_comb begin
    sel = ptr_q;
    found = 1'b0;
    j = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && i_req_valid[j]) begin
        sel = j;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) req_byte[k] = i_req_data[8*k +: 8];
  end
  assign accept = state_q == DATA && i_req_valid[idx_q] && i_tx_ready;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    grant_d = grant_q;
    burst_d = burst_q;
    idle_d = idle_q;
    timeout_d = 1'b0;
    leave = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = TAG_EN != 0 ? TAG : DATA;
        idx_d = sel;
        grant_d = NUM_REQ'(1) << sel;
        burst_d = '0;
        idle_d = '0;
      end
    end else if (state_q == TAG) begin
      state_d = i_tx_ready ? DATA : TAG;
    end else if (accept) begin
      burst_d = burst_q + 8'd1;
      idle_d = '0;
      leave = i_req_last[idx_q] || burst_q == 8'(MAX_BURST - 1);
    end else if (!i_req_valid[idx_q]) begin
      idle_d = idle_q == CW'(IDLE_TIMEOUT) ? idle_q : idle_q + 1'b1;
      timeout_d = IDLE_TIMEOUT != 0 && idle_q == CW'(IDLE_TIMEOUT - 1);
      leave = timeout_d;
    end
    if (leave) begin
      state_d = IDLE;
      ptr_d = idx_q;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      idx_q <= '0;
      grant_q <= '0;
      burst_q <= '0;
      idle_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      idle_q <= idle_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_tx_data = state_q == TAG ? TAG_BASE + 8'(idx_q) : state_q == DATA ? req_byte[idx_q] : 8'h00;
  assign o_tx_data_valid = state_q == TAG || (state_q == DATA && i_req_valid[idx_q]);
  assign o_req_ready = state_q == DATA && i_tx_ready ? grant_q : '0;
  assign o_grant = grant_q;
  assign o_busy = state_q != IDLE;
  assign o_timeout = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard and table-driven checks of the UART TX arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset;
  logic [8*N-1:0] i_req_data;
  logic [N-1:0] i_req_valid, i_req_last, o_req_ready, o_grant;
  logic [7:0] o_tx_data;
  logic o_tx_data_valid, i_tx_ready, o_busy, o_timeout;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4), .TAG_EN(1), .TAG_BASE(8'h80), .IDLE_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .i_req_data(i_req_data), .i_req_valid(i_req_valid),
    .i_req_last(i_req_last), .o_req_ready(o_req_ready), .o_tx_data(o_tx_data),
    .o_tx_data_valid(o_tx_data_valid), .i_tx_ready(i_tx_ready), .o_grant(o_grant),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );
  typedef struct {logic [7:0] data; logic [N-1:0] grant;} exp_t;
  typedef struct {int req; logic [7:0] data; int gidx;} vec_t;
  logic [8:0] rq [N][$];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push_exp(input logic [7:0] d, input int idx);
    exp_q.push_back('{d, 4'(1 << idx)});
  endtask
  task automatic push_frame(input int idx);
    push_exp(8'(8'h80 + idx), idx);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, o_grant, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_tx_valid"}, o_tx_data_valid, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_req_ready"}, o_req_ready, 0);
  endtask
  task automatic wait_quiet(input string name, input int max);
    for (int i = 0; i < max && (exp_q.size() != 0 || o_busy); i++) tick();
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy_end"}, o_busy, 0);
  endtask
  initial begin
    logic [N-1:0] pop;
    exp_t e;
    i_req_valid = '0;
    i_req_data = '0;
    i_req_last = '0;
    forever begin
      @(negedge clk);
      if (!reset && o_tx_data_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %0h expected none", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", o_tx_data, e.data);
          chk("tx_grant", o_grant, e.grant);
        end
      end
      pop = reset ? '0 : i_req_valid & o_req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (pop[k] && rq[k].size() != 0) void'(rq[k].pop_front());
        i_req_valid[k] = rq[k].size() != 0;
        i_req_data[8*k +: 8] = 8'h00;
        i_req_last[k] = 1'b0;
        if (rq[k].size() != 0) begin
          i_req_data[8*k +: 8] = rq[k][0][7:0];
          i_req_last[k] = rq[k][0][8];
        end
      end
    end
  end
  initial begin
    vec_t tbl[5];
    int cnt, first, last, bad_v, bad_d, bad_r, tos;
    tbl[0] = '{0, 8'hA0, 0};
    tbl[1] = '{1, 8'hA1, 1};
    tbl[2] = '{2, 8'hA2, 2};
    tbl[3] = '{3, 8'hA3, 3};
    tbl[4] = '{0, 8'hA4, 0};
    reset = 1'b1;
    i_tx_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("reset");
    i_tx_ready = 1'b1;
    rq[2].push_back({1'b0, 8'h11});
    rq[2].push_back({1'b0, 8'h22});
    rq[2].push_back({1'b1, 8'h33});
    push_frame(2);
    push_exp(8'h11, 2);
    push_exp(8'h22, 2);
    push_exp(8'h33, 2);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_grant == 4'b0100) cnt++;
    end
    chk("single_grant_cycles", cnt, 4);
    wait_quiet("single", 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rq[tbl[i].req].push_back({1'b1, tbl[i].data});
      push_frame(tbl[i].gidx);
      push_exp(tbl[i].data, tbl[i].gidx);
    end
    cnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_busy) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("rr_busy_cycles", cnt, 10);
    chk("rr_span_cycles", last - first + 1, 14);
    wait_quiet("rr", 20);
    for (int b = 1; b <= 10; b++) rq[1].push_back({b == 10, 8'(b)});
    rq[3].push_back({1'b0, 8'h31});
    rq[3].push_back({1'b1, 8'h32});
    push_frame(1);
    for (int b = 1; b <= 4; b++) push_exp(8'(b), 1);
    push_frame(3);
    push_exp(8'h31, 3);
    push_exp(8'h32, 3);
    push_frame(1);
    for (int b = 5; b <= 8; b++) push_exp(8'(b), 1);
    push_frame(1);
    push_exp(8'h09, 1);
    push_exp(8'h0A, 1);
    tick();
    wait_quiet("burst", 100);
    i_tx_ready = 1'b0;
    rq[2].push_back({1'b1, 8'h55});
    push_frame(2);
    push_exp(8'h55, 2);
    for (int i = 0; i < 10 && !o_busy; i++) tick();
    chk("bp_grant", o_grant, 4'b0100);
    bad_v = 0;
    bad_d = 0;
    bad_r = 0;
    for (int i = 0; i < 50; i++) begin
      if (!o_tx_data_valid) bad_v++;
      if (o_tx_data != 8'h82) bad_d++;
      if (o_req_ready != 0) bad_r++;
      tick();
    end
    chk("bp_valid_drops", bad_v, 0);
    chk("bp_data_changes", bad_d, 0);
    chk("bp_ready_seen", bad_r, 0);
    i_tx_ready = 1'b1;
    wait_quiet("bp", 20);
    rq[0].push_back({1'b0, 8'h77});
    rq[1].push_back({1'b1, 8'h99});
    push_frame(0);
    push_exp(8'h77, 0);
    push_frame(1);
    push_exp(8'h99, 1);
    cnt = 0;
    tos = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (o_grant == 4'b0001) cnt++;
      if (o_timeout) tos++;
    end
    chk("timeout_grant_cycles", cnt, 10);
    chk("timeout_pulses", tos, 1);
    wait_quiet("timeout", 20);
    for (int b = 0; b < 5; b++) rq[3].push_back({1'b0, 8'hC0 + 8'(b)});
    push_frame(3);
    for (int b = 0; b < 5; b++) push_exp(8'hC0 + 8'(b), 3);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_data_grant", o_grant, 4'b1000);
    chk("mid_data_ready", o_req_ready, 4'b1000);
    i_tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    for (int k = 0; k < N; k++) rq[k].delete();
    exp_q.delete();
    rq[1].push_back({1'b1, 8'hB1});
    rq[3].push_back({1'b1, 8'hB3});
    push_frame(1);
    push_exp(8'hB1, 1);
    push_frame(3);
    push_exp(8'hB3, 3);
    tick();
    reset = 1'b0;
    i_tx_ready = 1'b1;
    tick();
    chk("post_reset_grant", o_grant, 4'b0010);
    wait_quiet("post_reset", 30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
